bios_port: RTL and testbench

Processor-side endpoint of the BIOS control interface: decodes BIOS-class instructions (LOCK, RELEASE, BIOSINT, SETQUANTUM, GETTIME, GETQUANTUM, HALT) from the fetch stream, presents them to the BIOS as one-cycle opcode pulses, and writes returned BIOS data back to the register file. It also tracks the BIOS scheduler state. On preemption it stalls fetch, saves the PC and hands control back; on process resume it restores the saved PC. It sits between the processor decode stage and the BIOS.

---
 rtl/bios_pkg.sv | 56 +++++
 rtl/bios_op_decode.sv | 35 +++
 rtl/bios_port.sv | 253 +++++++++++++++++++++++++
 tb/tb_bios_port.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bios_pkg.sv
// ---------------------------------------------------------------------------
// bios_pkg
// Shared definitions for the processor-side BIOS port:
//   - BIOS-class opcode constants (big-endian opcode byte instr[0:7])
//   - bios_state encoding driven by the BIOS
//   - request / preempt FSM state encodings
//   - opcode classification struct produced by bios_op_decode
//   - helper to detect a bios_state transition between two samples
// ---------------------------------------------------------------------------
package bios_pkg;

    localparam logic [7:0] OP_NONE       = 8'h00;
    localparam logic [7:0] OP_HALT       = 8'h01;
    localparam logic [7:0] OP_GETTIME    = 8'hB0;
    localparam logic [7:0] OP_LOCK       = 8'hB1;
    localparam logic [7:0] OP_RELEASE    = 8'hB2;
    localparam logic [7:0] OP_GETQUANTUM = 8'hB3;
    localparam logic [7:0] OP_SETQUANTUM = 8'hB4;
    localparam logic [7:0] OP_BIOSINT    = 8'hB5;

    typedef enum logic [1:0] {
        BS_INV         = 2'd0,
        BS_BIOSEXEC    = 2'd1,
        BS_PROCESSEXEC = 2'd2,
        BS_PROCESSINT  = 2'd3
    } bios_state_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_ISSUE = 2'd1,
        R_WAIT  = 2'd2,
        R_WB    = 2'd3
    } req_state_e;

    typedef enum logic [1:0] {
        P_RUN  = 2'd0,
        P_PEND = 2'd1,
        P_BIOS = 2'd2
    } pre_state_e;

    typedef struct packed {
        logic is_bios;        // opcode is handled by the BIOS port
        logic needs_wb;       // BIOS returns data to the register file
        logic needs_operand;  // register value is forwarded to the BIOS
    } op_class_t;

    // True when the BIOS state moved from 'from_s' (previous sample) to
    // 'to_s' (current sample).
    function automatic logic bs_transition(input logic [1:0]  prev_s,
                                           input logic [1:0]  cur_s,
                                           input bios_state_e from_s,
                                           input bios_state_e to_s);
        return (prev_s == from_s) && (cur_s == to_s);
    endfunction

endpackage

// File: rtl/bios_op_decode.sv
// ---------------------------------------------------------------------------
// bios_op_decode
// Purely combinational classification of an 8-bit opcode.
// Ports:
//   opcode_i    in  [7:0]       opcode byte (instr[0:7])
//   op_class_o  out op_class_t  {is_bios, needs_wb, needs_operand}
// ---------------------------------------------------------------------------
module bios_op_decode
    import bios_pkg::*;
(
    input  logic [7:0] opcode_i,
    output op_class_t  op_class_o
);

    always_comb begin
        op_class_o = '0;
        case (opcode_i)
            OP_GETTIME, OP_GETQUANTUM: begin
                op_class_o.is_bios  = 1'b1;
                op_class_o.needs_wb = 1'b1;
            end
            OP_SETQUANTUM: begin
                op_class_o.is_bios       = 1'b1;
                op_class_o.needs_operand = 1'b1;
            end
            OP_LOCK, OP_RELEASE, OP_BIOSINT, OP_HALT: begin
                op_class_o.is_bios = 1'b1;
            end
            default: begin
                op_class_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/bios_port.sv
// ---------------------------------------------------------------------------
// bios_port
// Processor-side endpoint of the BIOS control interface.
//   - Request FSM (R_IDLE/R_ISSUE/R_WAIT/R_WB): accepts BIOS-class opcodes
//     from decode, presents them as a one-cycle opcode pulse, and writes
//     GETTIME/GETQUANTUM results back to the register file.
//   - Preempt FSM (P_RUN/P_PEND/P_BIOS): on bios_state 2->3 stalls fetch,
//     waits for the current instruction (and any in-flight request) to
//     finish, saves the PC and hands control to the BIOS; on 1->2 restores.
//
// Optional feature macro: BIOS_PORT_TIMEOUT_EN
//   defined   : a 16-bit counter runs in P_PEND; reaching TIMEOUT forces the
//               save and sets the sticky timeout_err.
//   undefined : P_PEND waits indefinitely, timeout_err is tied low.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   instr[0:31], instr_valid    fetched instruction (opcode [0:7], rd [8:12])
//   done_inst                   current instruction retired
//   pc                          current program counter
//   reg_rdata                   register value of instr[8:12] (SETQUANTUM)
//   bios_info, bios_state       BIOS response data / scheduler state
//   processor_opcode_operation  opcode pulse to BIOS (8'h00 when idle)
//   processor_info              SETQUANTUM operand
//   req_ready                   BIOS instruction can be accepted this cycle
//   rd_we/rd_addr/rd_wdata      register writeback
//   stall_fetch                 hold fetch while preemption is pending
//   ctx_save/ctx_restore        one-cycle context pulses
//   saved_pc                    PC captured at preemption
//   timeout_err                 sticky forced-save flag
// ---------------------------------------------------------------------------
module bios_port
    import bios_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = 16'd1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [0:31] instr,
    input  logic        instr_valid,
    input  logic        done_inst,
    input  logic [31:0] pc,
    input  logic [31:0] reg_rdata,
    input  logic [31:0] bios_info,
    input  logic [1:0]  bios_state,
    output logic [0:7]  processor_opcode_operation,
    output logic [31:0] processor_info,
    output logic        req_ready,
    output logic        rd_we,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_wdata,
    output logic        stall_fetch,
    output logic        ctx_save,
    output logic        ctx_restore,
    output logic [31:0] saved_pc,
    output logic        timeout_err
);

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [7:0] opcode;
    logic [4:0] rd_field;
    logic       unused_instr;

    assign opcode       = instr[0:7];
    assign rd_field     = instr[8:12];
    assign unused_instr = ^instr[13:31];

    op_class_t op_class;

    bios_op_decode u_decode (
        .opcode_i   (opcode),
        .op_class_o (op_class)
    );

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    req_state_e  r_state_q;
    pre_state_e  p_state_q;
    logic [1:0]  bs_prev_q;

    logic [7:0]  op_q;
    logic        wb_q;
    logic [4:0]  rd_addr_q;
    logic [31:0] proc_info_q;
    logic [7:0]  opcode_out_q;
    logic        rd_we_q;
    logic [31:0] rd_wdata_q;

    logic        stall_q;
    logic        ctx_save_q;
    logic        ctx_restore_q;
    logic [31:0] saved_pc_q;

    logic        accept;
    logic        save_ok;
    logic        tmo_hit;

    // No new request while a save is pending so the in-flight request is
    // the last one before the context switch.
    assign req_ready = rst_n && (r_state_q == R_IDLE) && (p_state_q != P_PEND);
    assign accept    = instr_valid && req_ready && op_class.is_bios;

    // Normal save: instruction retired and no request in flight.
    assign save_ok   = (p_state_q == P_PEND) && done_inst && (r_state_q == R_IDLE);

    // ------------------------------------------------------------------
    // Optional P_PEND timeout
    // ------------------------------------------------------------------
`ifdef BIOS_PORT_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;
    logic [15:0] tmo_cnt_d;
    logic        timeout_err_q;

    assign tmo_cnt_d = tmo_cnt_q + 16'd1;
    // Fires on the TIMEOUT-th clock edge spent in P_PEND.
    assign tmo_hit   = (p_state_q == P_PEND) && (tmo_cnt_d == TIMEOUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q     <= 16'd0;
            timeout_err_q <= 1'b0;
        end else begin
            if (p_state_q == P_PEND) begin
                tmo_cnt_q <= tmo_cnt_d;
            end else begin
                tmo_cnt_q <= 16'd0;
            end
            // Only a save that would not have happened anyway is an error.
            if (tmo_hit && !save_ok) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign tmo_hit        = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q    <= R_IDLE;
            op_q         <= OP_NONE;
            wb_q         <= 1'b0;
            rd_addr_q    <= 5'd0;
            proc_info_q  <= 32'd0;
            opcode_out_q <= OP_NONE;
            rd_we_q      <= 1'b0;
            rd_wdata_q   <= 32'd0;
        end else begin
            // Pulse outputs default low every cycle.
            opcode_out_q <= OP_NONE;
            rd_we_q      <= 1'b0;
            case (r_state_q)
                R_IDLE: begin
                    if (accept) begin
                        op_q      <= opcode;
                        wb_q      <= op_class.needs_wb;
                        rd_addr_q <= rd_field;
                        if (op_class.needs_operand) begin
                            proc_info_q <= reg_rdata;
                        end
                        r_state_q <= R_ISSUE;
                    end
                end
                R_ISSUE: begin
                    opcode_out_q <= op_q;
                    r_state_q    <= wb_q ? R_WAIT : R_IDLE;
                end
                R_WAIT: begin
                    // BIOS samples the opcode on this edge.
                    r_state_q <= R_WB;
                end
                R_WB: begin
                    rd_we_q    <= 1'b1;
                    rd_wdata_q <= bios_info;
                    r_state_q  <= R_IDLE;
                end
                default: begin
                    r_state_q <= R_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Preempt FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state_q     <= P_RUN;
            bs_prev_q     <= BS_INV;
            stall_q       <= 1'b0;
            ctx_save_q    <= 1'b0;
            ctx_restore_q <= 1'b0;
            saved_pc_q    <= 32'd0;
        end else begin
            bs_prev_q     <= bios_state;
            ctx_save_q    <= 1'b0;
            ctx_restore_q <= 1'b0;
            case (p_state_q)
                P_RUN: begin
                    if (bs_transition(bs_prev_q, bios_state, BS_PROCESSEXEC, BS_PROCESSINT)) begin
                        stall_q   <= 1'b1;
                        p_state_q <= P_PEND;
                    end
                end
                P_PEND: begin
                    // bios_state changes are ignored here: a 3->1 while
                    // pending still completes the save normally.
                    if (save_ok || tmo_hit) begin
                        saved_pc_q <= pc;
                        ctx_save_q <= 1'b1;
                        stall_q    <= 1'b0;
                        p_state_q  <= P_BIOS;
                    end
                end
                P_BIOS: begin
                    if (bs_transition(bs_prev_q, bios_state, BS_BIOSEXEC, BS_PROCESSEXEC)) begin
                        ctx_restore_q <= 1'b1;
                        p_state_q     <= P_RUN;
                    end
                end
                default: begin
                    p_state_q <= P_RUN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign processor_opcode_operation = opcode_out_q;
    assign processor_info             = proc_info_q;
    assign rd_we                      = rd_we_q;
    assign rd_addr                    = rd_addr_q;
    assign rd_wdata                   = rd_wdata_q;
    assign stall_fetch                = stall_q;
    assign ctx_save                   = ctx_save_q;
    assign ctx_restore                = ctx_restore_q;
    assign saved_pc                   = saved_pc_q;

endmodule

// File: tb/tb_bios_port.sv
// ---------------------------------------------------------------------------
// tb_bios_port
// Directed testbench for bios_port. Inputs change 1 ns after a rising edge
// and outputs are sampled 1 ns after the rising edge.
// Built with TIMEOUT=8; the P_PEND scenario checks the forced save when
// BIOS_PORT_TIMEOUT_EN is defined and indefinite waiting otherwise.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bios_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [0:31] instr;
    logic        instr_valid;
    logic        done_inst;
    logic [31:0] pc;
    logic [31:0] reg_rdata;
    logic [31:0] bios_info;
    logic [1:0]  bios_state;
    logic [0:7]  processor_opcode_operation;
    logic [31:0] processor_info;
    logic        req_ready;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        stall_fetch;
    logic        ctx_save;
    logic        ctx_restore;
    logic [31:0] saved_pc;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bios_port #(.TIMEOUT(16'd8)) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .instr                      (instr),
        .instr_valid                (instr_valid),
        .done_inst                  (done_inst),
        .pc                         (pc),
        .reg_rdata                  (reg_rdata),
        .bios_info                  (bios_info),
        .bios_state                 (bios_state),
        .processor_opcode_operation (processor_opcode_operation),
        .processor_info             (processor_info),
        .req_ready                  (req_ready),
        .rd_we                      (rd_we),
        .rd_addr                    (rd_addr),
        .rd_wdata                   (rd_wdata),
        .stall_fetch                (stall_fetch),
        .ctx_save                   (ctx_save),
        .ctx_restore                (ctx_restore),
        .saved_pc                   (saved_pc),
        .timeout_err                (timeout_err)
    );

    function automatic logic [0:31] mk_instr(input logic [7:0] op, input logic [4:0] rd);
        logic [0:31] w;
        w = {op, rd, 19'd0};
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; instr = '0; instr_valid = 1'b0; done_inst = 1'b0;
        pc = '0; reg_rdata = '0; bios_info = '0; bios_state = 2'd2;
        #1;
        step(); step();
        total++; if (processor_opcode_operation !== 8'h00) begin bad++; $display("FAIL reset_opcode: got %h expected 00", processor_opcode_operation); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        total++; if ({rd_we, stall_fetch, ctx_save, ctx_restore, timeout_err} !== 5'b0) begin bad++; $display("FAIL reset_flags: got %b expected 00000", {rd_we, stall_fetch, ctx_save, ctx_restore, timeout_err}); end
        total++; if ({processor_info, rd_wdata, saved_pc, rd_addr} !== '0) begin bad++; $display("FAIL reset_data: info=%h wdata=%h saved_pc=%h rd_addr=%h expected all 0", processor_info, rd_wdata, saved_pc, rd_addr); end
        rst_n = 1'b1;
        step(); step();
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_req_ready: got %b expected 1", req_ready); end
        $display("reset: outputs checked");
    endtask

    task automatic test_gettime();
        bios_info = 32'd77;
        instr = mk_instr(8'hB0, 5'd12); instr_valid = 1'b1;
        step();                                   // accepted at posedge k
        instr_valid = 1'b0;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL gettime_busy: req_ready got %b expected 0", req_ready); end
        total++; if (processor_opcode_operation !== 8'h00) begin bad++; $display("FAIL gettime_k0: opcode got %h expected 00", processor_opcode_operation); end
        step();                                   // k+1
        total++; if (processor_opcode_operation !== 8'hB0) begin bad++; $display("FAIL gettime_pulse: opcode got %h expected b0", processor_opcode_operation); end
        step();                                   // k+2
        total++; if (processor_opcode_operation !== 8'h00 || rd_we !== 1'b0) begin bad++; $display("FAIL gettime_k2: opcode=%h rd_we=%b expected 00/0", processor_opcode_operation, rd_we); end
        step();                                   // k+3
        total++; if (rd_we !== 1'b1 || rd_addr !== 5'd12 || rd_wdata !== 32'd77) begin bad++; $display("FAIL gettime_wb: rd_we=%b rd_addr=%0d rd_wdata=%0d expected 1/12/77", rd_we, rd_addr, rd_wdata); end
        step();                                   // k+4
        total++; if (rd_we !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL gettime_end: rd_we=%b req_ready=%b expected 0/1", rd_we, req_ready); end
        $display("gettime: rd=12 data=77");
    endtask

    task automatic test_setquantum();
        reg_rdata = 32'd500;
        instr = mk_instr(8'hB4, 5'd3); instr_valid = 1'b1;
        step();
        instr_valid = 1'b0; reg_rdata = 32'd9;
        total++; if (processor_info !== 32'd500) begin bad++; $display("FAIL setq_info: got %0d expected 500", processor_info); end
        step();
        total++; if (processor_opcode_operation !== 8'hB4 || processor_info !== 32'd500) begin bad++; $display("FAIL setq_pulse: opcode=%h info=%0d expected b4/500", processor_opcode_operation, processor_info); end
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (processor_opcode_operation !== 8'h00 || rd_we !== 1'b0) begin bad++; $display("FAIL setq_quiet: cycle %0d opcode=%h rd_we=%b expected 00/0", i, processor_opcode_operation, rd_we); end
        end
        $display("setquantum: operand=500");
    endtask

    task automatic test_nonbios();
        instr = mk_instr(8'h20, 5'd1); instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL nonbios_ignored: req_ready got %b expected 1", req_ready); end
        step();
        total++; if (processor_opcode_operation !== 8'h00) begin bad++; $display("FAIL nonbios_opcode: got %h expected 00", processor_opcode_operation); end
        $display("nonbios: opcode 20 ignored");
    endtask

    task automatic test_back_to_back();
        instr = mk_instr(8'hB1, 5'd0); instr_valid = 1'b1;
        step();                                   // LOCK accepted at k
        instr = mk_instr(8'hB2, 5'd0);            // decode presents RELEASE next
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_drop: req_ready got %b expected 0", req_ready); end
        step();                                   // k+1
        total++; if (processor_opcode_operation !== 8'hB1 || req_ready !== 1'b1) begin bad++; $display("FAIL b2b_lock: opcode=%h req_ready=%b expected b1/1", processor_opcode_operation, req_ready); end
        step();                                   // RELEASE accepted at k+2
        instr_valid = 1'b0;
        total++; if (processor_opcode_operation !== 8'h00) begin bad++; $display("FAIL b2b_gap: opcode got %h expected 00", processor_opcode_operation); end
        step();                                   // k+3
        total++; if (processor_opcode_operation !== 8'hB2) begin bad++; $display("FAIL b2b_release: opcode got %h expected b2", processor_opcode_operation); end
        step();
        $display("back_to_back: lock then release");
    endtask

    task automatic test_preempt();
        bios_state = 2'd3;
        step();                                   // 2->3 seen at E
        total++; if (stall_fetch !== 1'b1 || req_ready !== 1'b0) begin bad++; $display("FAIL preempt_stall: stall=%b req_ready=%b expected 1/0", stall_fetch, req_ready); end
        step();                                   // E+1
        total++; if (stall_fetch !== 1'b1 || ctx_save !== 1'b0) begin bad++; $display("FAIL preempt_hold: stall=%b ctx_save=%b expected 1/0", stall_fetch, ctx_save); end
        done_inst = 1'b1; pc = 32'h40;
        step();                                   // E+2
        done_inst = 1'b0; pc = 32'h44;
        total++; if (ctx_save !== 1'b1 || saved_pc !== 32'h40 || stall_fetch !== 1'b0) begin bad++; $display("FAIL preempt_save: ctx_save=%b saved_pc=%h stall=%b expected 1/40/0", ctx_save, saved_pc, stall_fetch); end
        step();
        total++; if (ctx_save !== 1'b0) begin bad++; $display("FAIL preempt_save_pulse: ctx_save got %b expected 0", ctx_save); end
        bios_state = 2'd1;
        step();
        total++; if (ctx_restore !== 1'b0) begin bad++; $display("FAIL restore_early: ctx_restore got %b expected 0", ctx_restore); end
        bios_state = 2'd2;
        step();
        total++; if (ctx_restore !== 1'b1) begin bad++; $display("FAIL restore_pulse: ctx_restore got %b expected 1", ctx_restore); end
        step();
        total++; if (ctx_restore !== 1'b0 || saved_pc !== 32'h40) begin bad++; $display("FAIL restore_end: ctx_restore=%b saved_pc=%h expected 0/40", ctx_restore, saved_pc); end
        $display("preempt: saved_pc=40 restored");
    endtask

    task automatic test_preempt_during_read();
        bios_info = 32'h1234;
        instr = mk_instr(8'hB3, 5'd7); instr_valid = 1'b1;
        step();                                   // accepted at k
        instr_valid = 1'b0; bios_state = 2'd3; done_inst = 1'b1; pc = 32'h80;
        step();                                   // k+1: preempt detected
        total++; if (processor_opcode_operation !== 8'hB3 || stall_fetch !== 1'b1) begin bad++; $display("FAIL pread_pulse: opcode=%h stall=%b expected b3/1", processor_opcode_operation, stall_fetch); end
        step();                                   // k+2
        total++; if (ctx_save !== 1'b0) begin bad++; $display("FAIL pread_nosave_k2: ctx_save got %b expected 0", ctx_save); end
        step();                                   // k+3
        total++; if (rd_we !== 1'b1 || rd_addr !== 5'd7 || rd_wdata !== 32'h1234 || ctx_save !== 1'b0) begin bad++; $display("FAIL pread_wb: rd_we=%b rd_addr=%0d wdata=%h ctx_save=%b expected 1/7/1234/0", rd_we, rd_addr, rd_wdata, ctx_save); end
        step();                                   // k+4
        done_inst = 1'b0;
        total++; if (ctx_save !== 1'b1 || saved_pc !== 32'h80 || rd_we !== 1'b0) begin bad++; $display("FAIL pread_save: ctx_save=%b saved_pc=%h rd_we=%b expected 1/80/0", ctx_save, saved_pc, rd_we); end
        bios_state = 2'd1;
        step();
        bios_state = 2'd2;
        step();
        total++; if (ctx_restore !== 1'b1) begin bad++; $display("FAIL pread_restore: ctx_restore got %b expected 1", ctx_restore); end
        step();
        $display("preempt_during_read: wb then save");
    endtask

    task automatic test_reset_midop();
        instr = mk_instr(8'hB0, 5'd9); instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total++; if (saved_pc !== 32'd0 || processor_opcode_operation !== 8'h00 || req_ready !== 1'b0) begin bad++; $display("FAIL midop_reset: saved_pc=%h opcode=%h req_ready=%b expected 0/00/0", saved_pc, processor_opcode_operation, req_ready); end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (processor_opcode_operation !== 8'h00 || rd_we !== 1'b0 || ctx_save !== 1'b0 || ctx_restore !== 1'b0) begin bad++; $display("FAIL midop_no_pulse: cycle %0d opcode=%h rd_we=%b save=%b restore=%b expected 00/0/0/0", i, processor_opcode_operation, rd_we, ctx_save, ctx_restore); end
        end
        $display("reset_midop: request aborted");
    endtask

    task automatic test_pend_wait();
        bios_state = 2'd3;
        step();                                   // enter P_PEND at E
        total++; if (stall_fetch !== 1'b1) begin bad++; $display("FAIL pend_enter: stall got %b expected 1", stall_fetch); end
`ifdef BIOS_PORT_TIMEOUT_EN
        pc = 32'h200;
        for (int i = 1; i <= 7; i++) begin
            step();
            total++; if (ctx_save !== 1'b0 || stall_fetch !== 1'b1) begin bad++; $display("FAIL tmo_early: cycle %0d ctx_save=%b stall=%b expected 0/1", i, ctx_save, stall_fetch); end
        end
        step();                                   // 8th edge in P_PEND
        total++; if (ctx_save !== 1'b1 || saved_pc !== 32'h200 || timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_save: ctx_save=%b saved_pc=%h err=%b expected 1/200/1", ctx_save, saved_pc, timeout_err); end
        step(); step(); step();
        total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_sticky: err got %b expected 1", timeout_err); end
        rst_n = 1'b0;
        #1;
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_clear: err got %b expected 0", timeout_err); end
        $display("pend_wait: forced save after 8 cycles");
`else
        for (int i = 0; i < 20; i++) begin
            step();
            total++; if (ctx_save !== 1'b0 || stall_fetch !== 1'b1 || timeout_err !== 1'b0) begin bad++; $display("FAIL pend_hold: cycle %0d ctx_save=%b stall=%b err=%b expected 0/1/0", i, ctx_save, stall_fetch, timeout_err); end
        end
        rst_n = 1'b0;
        #1;
        total++; if (stall_fetch !== 1'b0) begin bad++; $display("FAIL pend_reset: stall got %b expected 0", stall_fetch); end
        $display("pend_wait: held without timeout");
`endif
        step();
        rst_n = 1'b1;
        bios_state = 2'd2;
        step();
    endtask

    initial begin
        test_reset();
        test_gettime();
        test_setquantum();
        test_nonbios();
        test_back_to_back();
        test_preempt();
        test_preempt_during_read();
        test_reset_midop();
        test_pend_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
